// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the `sub` request bit.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-wide slice, WIDTH/DIGIT add cycles per operation.
// Optional subtract mode under SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_next;
    logic             c_msb;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    always_comb begin
        slice = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Carry into the slice MSB, recovered from its sum bit; meaningful on the last digit.
        c_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice[DIGIT-1];
    end

    if (WIDTH > DIGIT) begin : g_shift
        assign res_next = {slice[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign res_next = slice[DIGIT-1:0];
    end

    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_in = bus.sub ? ~bus.b : bus.b;
        c_in = bus.sub ? 1'b1 : bus.cin;
`else
        b_in = bus.b;
        c_in = bus.cin;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state != ADD) begin
            // IDLE and DONE both accept a new request.
            if (bus.start) begin
                a_sh  <= bus.a;
                b_sh  <= b_in;
                carry <= c_in;
                cnt   <= '0;
                state <= ADD;
            end else begin
                state <= IDLE;
            end
        end else begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_next;
            carry  <= slice[DIGIT];
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
                sum_q  <= res_next;
                cout_q <= slice[DIGIT];
                ovf_q  <= c_msb ^ slice[DIGIT];
                state  <= DONE;
            end
        end
    end

    assign bus.busy = (state == ADD);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks for serial_adder across several DIGIT widths.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) i8d1 ();
    serial_adder_if #(.WIDTH(8)) i8d4 ();
    serial_adder_if #(.WIDTH(4)) i4d1 ();
    serial_adder_if #(.WIDTH(4)) i4d2 ();
    serial_adder_if #(.WIDTH(4)) i4d4 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8d1 (.clk(clk), .rst(rst), .bus(i8d1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u8d4 (.clk(clk), .rst(rst), .bus(i8d4));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u4d1 (.clk(clk), .rst(rst), .bus(i4d1));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u4d2 (.clk(clk), .rst(rst), .bus(i4d2));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u4d4 (.clk(clk), .rst(rst), .bus(i4d4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        i8d1.a = a;
        i8d1.b = b;
        i8d1.cin = cin;
        i8d1.start = 1'b1;
    endtask

    // Ticks until i8d1.done or the budget runs out; t is the number of ticks taken.
    task automatic wait_done8(output int t);
        t = 0;
        while (i8d1.done !== 1'b1 && t < 30) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        int ndone;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({i8d1.busy, i8d1.done, i8d1.sum, i8d1.cout, i8d1.ovf} !== 12'h000)
            $display("FAIL reset_8d1 got=%h want=000", {i8d1.busy, i8d1.done, i8d1.sum, i8d1.cout, i8d1.ovf});
        else pass_cnt++;
        total_cnt++;
        if ({i8d4.busy, i8d4.done, i8d4.sum, i8d4.cout, i8d4.ovf} !== 12'h000)
            $display("FAIL reset_8d4 got=%h want=000", {i8d4.busy, i8d4.done, i8d4.sum, i8d4.cout, i8d4.ovf});
        else pass_cnt++;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i8d1.done === 1'b1 || i8d4.done === 1'b1 || i8d1.busy === 1'b1) ndone++;
        end
        total_cnt++;
        if (ndone !== 0) $display("FAIL reset_idle got=%0d want=0", ndone);
        else pass_cnt++;
    endtask

    task automatic test_digit1();
        int nb;
        drive8(8'hFF, 8'h01, 1'b0);
        tick();
        i8d1.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (i8d1.busy === 1'b1 && i8d1.done === 1'b0) nb++;
            tick();
        end
        total_cnt++;
        if (nb !== 8) $display("FAIL d1_busy_cycles got=%0d want=8", nb);
        else pass_cnt++;
        total_cnt++;
        if ({i8d1.done, i8d1.busy} !== 2'b10) $display("FAIL d1_done_at_k9 got=%b want=10", {i8d1.done, i8d1.busy});
        else pass_cnt++;
        total_cnt++;
        if ({i8d1.cout, i8d1.ovf, i8d1.sum} !== 10'b10_0000_0000)
            $display("FAIL d1_result got=%b want=1000000000", {i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (i8d1.done !== 1'b0) $display("FAIL d1_done_pulse got=%b want=0", i8d1.done);
        else pass_cnt++;
    endtask

    task automatic test_digit4();
        int nb;
        i8d4.a = 8'h7F;
        i8d4.b = 8'h00;
        i8d4.cin = 1'b1;
        i8d4.start = 1'b1;
        tick();
        i8d4.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 2; i++) begin
            if (i8d4.busy === 1'b1 && i8d4.done === 1'b0) nb++;
            tick();
        end
        total_cnt++;
        if (nb !== 2) $display("FAIL d4_busy_cycles got=%0d want=2", nb);
        else pass_cnt++;
        total_cnt++;
        if ({i8d4.done, i8d4.busy} !== 2'b10) $display("FAIL d4_done_at_k3 got=%b want=10", {i8d4.done, i8d4.busy});
        else pass_cnt++;
        total_cnt++;
        if ({i8d4.cout, i8d4.ovf, i8d4.sum} !== 10'b01_1000_0000)
            $display("FAIL d4_result got=%b want=0110000000", {i8d4.cout, i8d4.ovf, i8d4.sum});
        else pass_cnt++;
    endtask

    task automatic test_busy_protect();
        int ndone;
        logic [7:0] s;
        drive8(8'h03, 8'h04, 1'b0);
        tick();
        i8d1.start = 1'b0;
        tick();
        tick();
        drive8(8'h09, 8'h09, 1'b1);
        tick();
        i8d1.start = 1'b0;
        i8d1.a = 8'h00;
        i8d1.b = 8'h00;
        i8d1.cin = 1'b0;
        ndone = 0;
        s = 8'hxx;
        for (int i = 0; i < 30; i++) begin
            if (i8d1.done === 1'b1) begin
                if (ndone == 0) s = i8d1.sum;
                ndone++;
            end
            tick();
        end
        total_cnt++;
        if (ndone !== 1) $display("FAIL protect_done_count got=%0d want=1", ndone);
        else pass_cnt++;
        total_cnt++;
        if (s !== 8'h07) $display("FAIL protect_sum got=%h want=07", s);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t;
        drive8(8'h10, 8'h20, 1'b0);
        tick();
        i8d1.start = 1'b0;
        wait_done8(t);
        total_cnt++;
        if (t !== 8) $display("FAIL b2b_first_latency got=%0d want=8", t);
        else pass_cnt++;
        total_cnt++;
        if ({i8d1.cout, i8d1.ovf, i8d1.sum} !== 10'b00_0011_0000)
            $display("FAIL b2b_first_result got=%b want=0000110000", {i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        drive8(8'hC8, 8'h64, 1'b1);
        tick();
        i8d1.start = 1'b0;
        total_cnt++;
        if ({i8d1.busy, i8d1.done} !== 2'b10) $display("FAIL b2b_busy_again got=%b want=10", {i8d1.busy, i8d1.done});
        else pass_cnt++;
        total_cnt++;
        if (i8d1.sum !== 8'h30) $display("FAIL b2b_sum_held got=%h want=30", i8d1.sum);
        else pass_cnt++;
        wait_done8(t);
        total_cnt++;
        if (t !== 8) $display("FAIL b2b_second_latency got=%0d want=8", t);
        else pass_cnt++;
        total_cnt++;
        if ({i8d1.cout, i8d1.ovf, i8d1.sum} !== 10'b10_0010_1101)
            $display("FAIL b2b_second_result got=%b want=1000101101", {i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midop();
        int ndone;
        int t;
        drive8(8'h55, 8'hAA, 1'b0);
        tick();
        i8d1.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({i8d1.busy, i8d1.done, i8d1.sum} !== 10'h000)
            $display("FAIL midrst_clear got=%h want=000", {i8d1.busy, i8d1.done, i8d1.sum});
        else pass_cnt++;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (i8d1.done === 1'b1) ndone++;
            tick();
        end
        total_cnt++;
        if (ndone !== 0) $display("FAIL midrst_no_done got=%0d want=0", ndone);
        else pass_cnt++;
        drive8(8'h12, 8'h34, 1'b0);
        tick();
        i8d1.start = 1'b0;
        wait_done8(t);
        total_cnt++;
        if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== 11'b100_0100_0110)
            $display("FAIL midrst_next_add got=%b want=10001000110", {i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        tick();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int t;
        i8d1.sub = 1'b1;
        drive8(8'h05, 8'h07, 1'b0);
        tick();
        i8d1.start = 1'b0;
        wait_done8(t);
        total_cnt++;
        if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== 11'b100_1111_1110)
            $display("FAIL sub_5m7 got=%b want=10011111110", {i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        tick();
        drive8(8'h80, 8'h01, 1'b0);
        tick();
        i8d1.start = 1'b0;
        wait_done8(t);
        total_cnt++;
        if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== 11'b111_0111_1111)
            $display("FAIL sub_80m1 got=%b want=11101111111", {i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum});
        else pass_cnt++;
        i8d1.sub = 1'b0;
        tick();
    endtask
`endif

    task automatic test_sweep4();
        logic [5:0] g1, g2, g4;
        logic [5:0] exp_v;
        logic [4:0] full;
        logic [3:0] av, bv;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    av = 4'(a);
                    bv = 4'(b);
                    i4d1.a = av; i4d1.b = bv; i4d1.cin = 1'(c); i4d1.start = 1'b1;
                    i4d2.a = av; i4d2.b = bv; i4d2.cin = 1'(c); i4d2.start = 1'b1;
                    i4d4.a = av; i4d4.b = bv; i4d4.cin = 1'(c); i4d4.start = 1'b1;
                    tick();
                    i4d1.start = 1'b0;
                    i4d2.start = 1'b0;
                    i4d4.start = 1'b0;
                    g1 = 6'bx;
                    g2 = 6'bx;
                    g4 = 6'bx;
                    for (int k = 0; k < 8; k++) begin
                        tick();
                        if (i4d1.done === 1'b1) g1 = {i4d1.ovf, i4d1.cout, i4d1.sum};
                        if (i4d2.done === 1'b1) g2 = {i4d2.ovf, i4d2.cout, i4d2.sum};
                        if (i4d4.done === 1'b1) g4 = {i4d4.ovf, i4d4.cout, i4d4.sum};
                    end
                    full = 5'(a) + 5'(b) + 5'(c);
                    exp_v = {(av[3] == bv[3]) && (full[3] != av[3]), full};
                    total_cnt++;
                    if (g1 !== exp_v) $display("FAIL sweep_d1 a=%0d b=%0d c=%0d got=%b want=%b", a, b, c, g1, exp_v);
                    else pass_cnt++;
                    total_cnt++;
                    if (g2 !== exp_v) $display("FAIL sweep_d2 a=%0d b=%0d c=%0d got=%b want=%b", a, b, c, g2, exp_v);
                    else pass_cnt++;
                    total_cnt++;
                    if (g4 !== exp_v) $display("FAIL sweep_d4 a=%0d b=%0d c=%0d got=%b want=%b", a, b, c, g4, exp_v);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        i8d1.start = 1'b0; i8d1.a = '0; i8d1.b = '0; i8d1.cin = 1'b0;
        i8d4.start = 1'b0; i8d4.a = '0; i8d4.b = '0; i8d4.cin = 1'b0;
        i4d1.start = 1'b0; i4d1.a = '0; i4d1.b = '0; i4d1.cin = 1'b0;
        i4d2.start = 1'b0; i4d2.a = '0; i4d2.b = '0; i4d2.cin = 1'b0;
        i4d4.start = 1'b0; i4d4.a = '0; i4d4.b = '0; i4d4.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        i8d1.sub = 1'b0; i8d4.sub = 1'b0;
        i4d1.sub = 1'b0; i4d2.sub = 1'b0; i4d4.sub = 1'b0;
`endif
        test_reset();
        test_digit1();
        test_digit4();
        test_busy_protect();
        test_back_to_back();
        test_reset_midop();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_sweep4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
